score_request_arbiter: RTL and testbench
========================================

# score_request_arbiter

Arbitrates scoring events from several game sources (prize-chute sensors, bonus triggers) onto the processor's single score-increment handshake. Each event pulse is queued in a per-source saturating pending counter. Round-robin arbitration picks one source at a time and runs a four-phase handshake with the processor. The block sits between the crane game logic and the processor's `need_to_increment_score` / `finished_incrementing_score` pins inside the top-level wrapper.

## Interface
- `NUM_SRC`, 4: number of event sources (2..8).
- `CNT_W`, 4: pending-counter width per source; saturates at 2^CNT_W-1.
- `TIMEOUT`, 1024: max cycles in REQ before abandoning the handshake.
- `SEL_W`, $clog2(NUM_SRC): width of `grant_src`.

- `clock`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `event_pulse`  in  NUM_SRC  one-cycle-per-event request, one bit per source.
- `need_to_increment_score`  out  1  registered request to processor.
- `finished_incrementing_score`  in  1  processor acknowledge (level).
- `grant_src`  out  SEL_W  source currently being serviced; valid while `busy`.
- `busy`  out  1  FSM not in IDLE.
- `pending_overflow`  out  NUM_SRC  sticky per-source: an event was dropped at saturation.
- `timeout_err`  out  1  sticky: a handshake timed out.
- `serviced_count`  out  16  completed increments; wraps 0xFFFF→0.

## Operation
- Reset values: all outputs 0; pending counters 0; RR pointer = NUM_SRC-1, so source 0 wins first; FSM = IDLE; timeout counter 0.
- Pending counters, per source each cycle:
  - event only: +1; if already saturated, hold and set `pending_overflow[i]`.
  - decrement only: -1.
  - both in the same cycle: net unchanged; no overflow flag even when saturated.
- FSM states IDLE, REQ, WAIT_DROP.
  - IDLE:
    - If any pending count is nonzero, select the first nonzero source searching from RR pointer+1 upward, with modulo wrap.
    - Latch it into `grant_src` and set the RR pointer to it.
    - Go to REQ with `need_to_increment_score`=1.
    - Registered pending values are used, so an event arriving this cycle is not seen until the next cycle.
  - REQ:
    - If `finished_incrementing_score`=1: decrement pending[`grant_src`], increment `serviced_count`, drive need=0, go to WAIT_DROP.
    - Else if the timeout counter equals TIMEOUT-1: drive need=0, set `timeout_err`, go to WAIT_DROP. Pending is retained and nothing is counted.
    - Else increment the timeout counter.
  - WAIT_DROP: when `finished_incrementing_score`=0, clear the timeout counter and go to IDLE. Stays indefinitely while finished stays high.
- `grant_src` holds its value through REQ and WAIT_DROP.
- Sticky flags clear only on `reset`.
- `reset` mid-handshake: need drops to 0 on the next edge and all pending events are discarded.

## Timing
- Event latency: `event_pulse[i]` high in cycle 0 → pending=1 in cycle 1 → need=1 in cycle 2, with the FSM idle.
- Ack latency: finished sampled high at edge k → need low after edge k (cycle k+1); decrement and count are visible the same cycle.
- Minimum handshake throughput: 3 cycles per increment (REQ, WAIT_DROP, IDLE), with the processor acking immediately and finished dropping in one cycle.
- A finished=1 seen in IDLE or WAIT_DROP is ignored: no decrement.
- Timeout: need stays high for exactly TIMEOUT cycles when there is no ack.
- RR fairness: with all sources continuously pending, grants cycle 0,1,…,NUM_SRC-1,0.

## Test plan
- Single event: pulse src 2 once; processor acks 2 cycles after need rises and drops finished 1 cycle later → need high cycles 2–4, `grant_src`=2, `serviced_count`=1, `busy` low afterward.
- Simultaneous burst: pulse all 4 sources in one cycle; ack each immediately → grant order 0,1,2,3, `serviced_count`=4, all pending 0.
- Saturation: 17 pulses on src 1 with the processor never acking, CNT_W=4 → pending[1]=15, `pending_overflow`=4'b0010.
- Timeout with TIMEOUT=8: pulse src 0, no ack → need high exactly 8 cycles, `timeout_err`=1, pending[0] still 1; subsequent ack services it, `serviced_count`=1.
- Same-cycle inc/dec: src 3 pending=1; pulse src 3 in the cycle the ack is sampled → pending[3] stays 1, and a second handshake for src 3 follows.
- Reset mid-REQ: assert `reset` one cycle while need=1 with pending {2,0,1,0} → next cycle all outputs 0, FSM IDLE, no further requests.

Source files
------------

// File: rtl/score_request_arbiter.sv
// score_request_arbiter: round-robin arbitration of queued score events onto a four-phase increment handshake
module score_request_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 1024,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] event_pulse,
  output logic               need_to_increment_score,
  input  logic               finished_incrementing_score,
  output logic [SEL_W-1:0]   grant_src,
  output logic               busy,
  output logic [NUM_SRC-1:0] pending_overflow,
  output logic               timeout_err,
  output logic [15:0]        serviced_count
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_DROP} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0]   pend [NUM_SRC];
  logic [SEL_W-1:0]   rr_ptr, pick;
  logic               found, ack, last, timed_out;
  logic [TW-1:0]      tcnt;
  logic [NUM_SRC-1:0] dec;
  int                 j;
  assign ack       = state == REQ && finished_incrementing_score;
  assign last      = tcnt == TW'(TIMEOUT - 1);
  assign timed_out = state == REQ && !finished_incrementing_score && last;
  assign dec       = ack ? NUM_SRC'(1) << grant_src : '0;
  // nearest nonzero source after the RR pointer wins; scanning far-to-near lets the nearest overwrite
  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      j = (int'(rr_ptr) + k) % NUM_SRC;
      if (pend[j] != '0) begin
        found = 1'b1;
        pick  = SEL_W'(j);
      end
    end
  end
  // state register
  always_ff @(posedge clock) begin
    state <= reset ? IDLE : state_nx;
  end
  // next-state logic
  always_comb begin
    state_nx = state == IDLE ? (found ? REQ : IDLE) :
               state == REQ  ? ((finished_incrementing_score || last) ? WAIT_DROP : REQ) :
               (finished_incrementing_score ? WAIT_DROP : IDLE);
  end
  // outputs decoded from the registered state
  always_comb begin
    need_to_increment_score = state == REQ;
    busy                    = state != IDLE;
  end
  // grant latch, timeout counter, service counter and sticky timeout flag
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr         <= SEL_W'(NUM_SRC - 1);
      grant_src      <= '0;
      tcnt           <= '0;
      serviced_count <= '0;
      timeout_err    <= 1'b0;
    end else begin
      if (state == IDLE && found) begin
        grant_src <= pick;
        rr_ptr    <= pick;
      end
      if (state == REQ && !finished_incrementing_score && !last) tcnt <= tcnt + TW'(1);
      if (state == WAIT_DROP && !finished_incrementing_score) tcnt <= '0;
      if (ack) serviced_count <= serviced_count + 16'd1;
      if (timed_out) timeout_err <= 1'b1;
    end
  end
  // saturating pending counters; a simultaneous event and decrement cancel out
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (reset) begin
        pend[i]             <= '0;
        pending_overflow[i] <= 1'b0;
      end else if (event_pulse[i] && !dec[i]) begin
        if (&pend[i]) pending_overflow[i] <= 1'b1;
        else pend[i] <= pend[i] + CNT_W'(1);
      end else if (dec[i] && !event_pulse[i]) begin
        pend[i] <= pend[i] - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_score_request_arbiter.sv
// tb_score_request_arbiter: directed and randomized checks against a behavioural reference model
module tb_score_request_arbiter;
  localparam int N = 4;
  localparam int T = 8;
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] event_pulse = '0;
  logic         finished = 1'b0;
  logic         need, busy, timeout_err;
  logic [1:0]   grant_src;
  logic [N-1:0] pending_overflow;
  logic [15:0]  serviced_count;
  int n_chk = 0, n_err = 0;
  int m_pend [N];
  int m_phase, m_grant, m_rr, m_t, m_srv, m_to;
  logic [N-1:0] m_ovf;
  int q_grants [$];
  int cnt;

  score_request_arbiter #(.NUM_SRC(N), .CNT_W(4), .TIMEOUT(T)) dut (
    .clock(clock), .reset(reset), .event_pulse(event_pulse),
    .need_to_increment_score(need), .finished_incrementing_score(finished),
    .grant_src(grant_src), .busy(busy), .pending_overflow(pending_overflow),
    .timeout_err(timeout_err), .serviced_count(serviced_count)
  );

  always #5 clock = ~clock;

  task check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // phase 0 = idle, 1 = requesting, 2 = waiting for acknowledge to drop
  task model_step(input logic [N-1:0] ev, input logic fin, input logic rs);
    int dec, p;
    dec = -1;
    p = m_phase;
    if (rs) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_ovf = '0; m_phase = 0; m_grant = 0; m_rr = N - 1; m_t = 0; m_srv = 0; m_to = 0;
      return;
    end
    if (p == 0) begin
      for (int k = 1; k <= N; k++)
        if (m_pend[(m_rr + k) % N] > 0) begin
          m_grant = (m_rr + k) % N; m_rr = m_grant; m_phase = 1;
          break;
        end
    end else if (p == 1) begin
      if (fin) begin dec = m_grant; m_srv = (m_srv + 1) % 65536; m_phase = 2; end
      else if (m_t == T - 1) begin m_to = 1; m_phase = 2; end
      else m_t++;
    end else if (!fin) begin
      m_t = 0; m_phase = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (ev[i] && i != dec) begin
        if (m_pend[i] == 15) m_ovf[i] = 1'b1;
        else m_pend[i]++;
      end else if (!ev[i] && i == dec) m_pend[i]--;
    end
  endtask

  task cyc(input logic [N-1:0] ev, input logic fin, input logic rs);
    @(negedge clock);
    event_pulse = ev; finished = fin; reset = rs;
    model_step(ev, fin, rs);
    @(posedge clock);
    #1;
    check("need", need, m_phase == 1);
    check("busy", busy, m_phase != 0);
    if (m_phase != 0) check("grant", grant_src, m_grant);
    check("ovf", pending_overflow, m_ovf);
    check("timeout_err", timeout_err, m_to);
    check("serviced", serviced_count, m_srv);
  endtask

  // processor that acknowledges immediately and drops one cycle later
  task serve(input int max_cycles, input int target);
    for (int k = 0; k < max_cycles && m_srv < target; k++) begin
      if (need) q_grants.push_back(grant_src);
      cyc('0, need, 1'b0);
    end
  endtask

  initial begin
    cyc('0, 0, 1); cyc('0, 0, 1);
    check("rst_grant", grant_src, 0);
    check("rst_need", need, 0);
    // single event on source 2 with a slow processor
    cyc(4'b0100, 0, 0);
    cyc('0, 0, 0);
    check("single_need_rise", need, 1);
    cyc('0, 0, 0); cyc('0, 1, 0); cyc('0, 0, 0); cyc('0, 0, 0);
    check("single_grant", grant_src, 2);
    check("single_served", serviced_count, 1);
    check("single_idle", busy, 0);
    // burst on all sources, order must be 0,1,2,3
    cyc('0, 0, 1);
    cyc(4'b1111, 0, 0);
    q_grants.delete();
    serve(40, 4);
    check("burst_served", serviced_count, 4);
    check("burst_len", q_grants.size(), 4);
    for (int k = 0; k < 4 && k < q_grants.size(); k++) check("burst_order", q_grants[k], k);
    cyc('0, 0, 0); cyc('0, 0, 0);
    check("burst_drained", busy, 0);
    // saturation of source 1
    cyc('0, 0, 1);
    for (int k = 0; k < 17; k++) cyc(4'b0010, 0, 0);
    check("sat_ovf", pending_overflow, 4'b0010);
    serve(200, 15);
    check("sat_served", serviced_count, 15);
    for (int k = 0; k < 4; k++) cyc('0, 0, 0);
    check("sat_drained", busy, 0);
    // timeout on source 0
    cyc('0, 0, 1);
    cyc(4'b0001, 0, 0);
    cyc('0, 0, 0);
    cnt = 0;
    for (int k = 0; k < 20 && need; k++) begin cnt++; cyc('0, 0, 0); end
    check("to_need_cycles", cnt, T);
    check("to_flag", timeout_err, 1);
    check("to_not_counted", serviced_count, 0);
    serve(40, 1);
    check("to_served_later", serviced_count, 1);
    // same-cycle event and decrement on source 3
    cyc('0, 0, 1);
    cyc(4'b1000, 0, 0);
    cyc('0, 0, 0);
    cyc(4'b1000, 1, 0);
    cyc('0, 0, 0);
    cyc('0, 0, 0);
    check("samecyc_rereq", need, 1);
    check("samecyc_grant", grant_src, 3);
    serve(40, 2);
    check("samecyc_served", serviced_count, 2);
    // reset in the middle of a request
    cyc('0, 0, 1);
    cyc(4'b0101, 0, 0);
    cyc(4'b0001, 0, 0);
    check("midrst_req", need, 1);
    cyc('0, 0, 1);
    for (int k = 0; k < 10; k++) cyc('0, 0, 0);
    check("midrst_quiet", busy, 0);
    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] ev;
      logic f;
      ev = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      f  = ($urandom_range(0, 9) < 7) ? need : 1'($urandom);
      cyc(ev, f, $urandom_range(0, 499) == 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
